repetition_detector_block: RTL and testbench



---
 rtl/repetition_detector_block.sv | 136 +++++++++++++
 tb/tb_repetition_detector_block.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/repetition_detector_block.sv
// repetition_detector_block: a registered stream filter with a one-cycle latency.
// Each accepted group of GROUP_SIZE values is forwarded unchanged. Two masks go with it:
//   a pairwise repetition matrix and a per-value zero mask.
// A configure pulse arms the block for num_iters * num_reads_per_iter groups.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   configure           latch the loop bounds, clear the counters, enter RUN or DONE
//   num_iters           iteration count, sampled on configure
//   num_reads_per_iter  groups per iteration, sampled on configure
//   data_in / valid_in  input group (value k at [k*DATA_WIDTH +: DATA_WIDTH]) and its valid
//   avail_out           block can accept a group this cycle (combinational)
//   data_out            {zero_info, rep_info, values}, registered
//   valid_out           data_out is valid
//   avail_in            downstream accepts data_out this cycle
module repetition_detector_block #(
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned GROUP_SIZE             = 4,
    parameter int unsigned LOG_MAX_ITERS          = 16,
    parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  configure,
    input  logic [LOG_MAX_ITERS-1:0]              num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]     num_reads_per_iter,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]      data_in,
    input  logic                                  valid_in,
    output logic                                  avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH+GROUP_SIZE*GROUP_SIZE+GROUP_SIZE-1:0] data_out,
    output logic                                  valid_out,
    input  logic                                  avail_in
);

    localparam int unsigned GS            = GROUP_SIZE;
    localparam int unsigned VAL_W         = GS * DATA_WIDTH;
    localparam int unsigned REP_INFO_BITS = GS * GS;
    localparam int unsigned ZERO_INFO     = GS;
    localparam int unsigned OUT_W         = VAL_W + REP_INFO_BITS + ZERO_INFO;
    localparam int unsigned IW            = LOG_MAX_ITERS;
    localparam int unsigned RW            = LOG_MAX_READS_PER_ITER;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    iters_q, iters_d;
    logic [RW-1:0]    reads_q, reads_d;
    logic [IW-1:0]    iter_cnt_q, iter_cnt_d;
    logic [RW-1:0]    read_cnt_q, read_cnt_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [REP_INFO_BITS-1:0] rep_c;
    logic [ZERO_INFO-1:0]     zero_c;
    logic                     accept_c;

    // Ready whenever running and the output register is empty or draining this cycle.
    assign avail_out = (state_q == S_RUN) & (~valid_q | avail_in);
    assign accept_c  = valid_in & avail_out & ~configure;
    assign data_out  = data_q;
    assign valid_out = valid_q;

    // rep_info[k*GS+l] marks value k repeating an earlier value l (strict lower triangle only).
    always_comb begin
        rep_c  = '0;
        zero_c = '0;
        for (int k = 0; k < int'(GS); k++) begin
            zero_c[k] = (data_in[k*DATA_WIDTH +: DATA_WIDTH] == '0);
            for (int l = 0; l < k; l++) begin
                rep_c[k*GS + l] = (data_in[k*DATA_WIDTH +: DATA_WIDTH] ==
                                   data_in[l*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Next-state: configure wins over a same-cycle handshake.
    always_comb begin
        state_d    = state_q;
        iters_d    = iters_q;
        reads_d    = reads_q;
        iter_cnt_d = iter_cnt_q;
        read_cnt_d = read_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;

        if (configure) begin
            iters_d    = num_iters;
            reads_d    = num_reads_per_iter;
            iter_cnt_d = '0;
            read_cnt_d = '0;
            state_d    = ((num_iters == '0) || (num_reads_per_iter == '0)) ? S_DONE : S_RUN;
        end else if (accept_c) begin
            // Bounds are non-zero in RUN, so the minus-one compares cannot underflow.
            if (read_cnt_q == reads_q - RW'(1)) begin
                read_cnt_d = '0;
                iter_cnt_d = iter_cnt_q + IW'(1);
                if (iter_cnt_q == iters_q - IW'(1)) begin
                    state_d = S_DONE;
                end
            end else begin
                read_cnt_d = read_cnt_q + RW'(1);
            end
        end

        if (accept_c) begin
            data_d  = {zero_c, rep_c, data_in};
            valid_d = 1'b1;
        end else if (valid_q && avail_in) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            iters_q    <= '0;
            reads_q    <= '0;
            iter_cnt_q <= '0;
            read_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            iters_q    <= iters_d;
            reads_q    <= reads_d;
            iter_cnt_q <= iter_cnt_d;
            read_cnt_q <= read_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_repetition_detector_block.sv
// Self-checking bench for repetition_detector_block.
// It combines table-driven vectors, directed multi-cycle sequences and randomized traffic.
// All of these are checked against a group-count reference model.
module tb_repetition_detector_block;

    localparam int DW    = 8;
    localparam int GS    = 4;
    localparam int OUT_W = GS*DW + GS*GS + GS;

    logic              clk = 1'b0;
    logic              rst;
    logic              configure;
    logic [15:0]       num_iters;
    logic [15:0]       num_reads_per_iter;
    logic [GS*DW-1:0]  data_in;
    logic              valid_in;
    logic              avail_out;
    logic [OUT_W-1:0]  data_out;
    logic              valid_out;
    logic              avail_in;

    repetition_detector_block dut (
        .clk                (clk),
        .rst                (rst),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .data_in            (data_in),
        .valid_in           (valid_in),
        .avail_out          (avail_out),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .avail_in           (avail_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a remaining-group budget plus the expected output register.
    longint           m_left;
    bit               m_run;
    bit               m_valid;
    logic [OUT_W-1:0] m_data;
    bit               obs_avail;

    typedef struct {
        logic [7:0]  v0, v1, v2, v3;
        logic [15:0] rep;
        logic [3:0]  zero;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [GS*DW-1:0] grp(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Expected payload built from the definitions: a value repeats if any earlier value equals it.
    function automatic logic [OUT_W-1:0] expect_out(input logic [GS*DW-1:0] g);
        logic [7:0]  v[GS];
        logic [15:0] rep;
        logic [3:0]  zero;
        rep  = '0;
        zero = '0;
        for (int k = 0; k < GS; k++) v[k] = g[k*DW +: DW];
        for (int k = 0; k < GS; k++) begin
            zero[k] = (v[k] == 8'd0);
            for (int l = 0; l < k; l++)
                if (v[l] == v[k]) rep[k*GS + l] = 1'b1;
        end
        return {zero, rep, g};
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_run   = 0;
        m_valid = 0;
        m_data  = '0;
    endtask

    // One clock: check avail_out mid-cycle, advance the model at the edge, check outputs after it.
    task automatic cycle();
        bit m_avail, m_acc;
        @(negedge clk);
        m_avail   = m_run && (!m_valid || avail_in);
        obs_avail = avail_out;
        check("avail_out", 64'(avail_out), 64'(m_avail));
        m_acc = valid_in && m_avail && !configure;
        @(posedge clk);
        if (configure) begin
            m_left = longint'(num_iters) * longint'(num_reads_per_iter);
            m_run  = (m_left != 0);
        end else if (m_acc) begin
            m_left--;
            m_run = (m_left != 0);
        end
        if (m_acc) begin
            m_valid = 1;
            m_data  = expect_out(data_in);
        end else if (m_valid && avail_in) begin
            m_valid = 0;
        end
        #1;
        check("valid_out", 64'(valid_out), 64'(m_valid));
        check("data_out", 64'(data_out), 64'(m_data));
    endtask

    task automatic do_configure(input int ni, input int nr);
        configure          = 1'b1;
        num_iters          = 16'(ni);
        num_reads_per_iter = 16'(nr);
        valid_in           = 1'b0;
        cycle();
        configure = 1'b0;
    endtask

    vec_t vecs[6];
    int   acc_cnt;
    logic [OUT_W-1:0] held;

    initial begin
        vecs[0] = '{8'd0, 8'd1, 8'd2, 8'd3, 16'h0000, 4'h1};
        vecs[1] = '{8'd0, 8'd0, 8'd2, 8'd3, 16'h0010, 4'h3};
        vecs[2] = '{8'd0, 8'd0, 8'd0, 8'd3, 16'h0310, 4'h7};
        vecs[3] = '{8'd0, 8'd0, 8'd0, 8'd0, 16'h7310, 4'hF};
        vecs[4] = '{8'd5, 8'd9, 8'd7, 8'd3, 16'h0000, 4'h0};
        vecs[5] = '{8'd7, 8'd7, 8'd3, 8'd7, 16'h3010, 4'h0};

        rst = 1'b1; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
        data_in = '0; valid_in = 1'b0; avail_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset valid_out", 64'(valid_out), 64'd0);
        check("reset data_out", 64'(data_out), 64'd0);
        check("reset avail_out", 64'(avail_out), 64'd0);
        rst = 1'b0;

        // IDLE ignores traffic until configured.
        valid_in = 1'b1; data_in = grp(1, 2, 3, 4);
        cycle();

        // Table vectors, back to back.
        do_configure(1, 6);
        for (int i = 0; i < 6; i++) begin
            data_in  = grp(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
            valid_in = 1'b1;
            avail_in = 1'b1;
            cycle();
            check($sformatf("vec%0d values", i), 64'(data_out[31:0]), 64'(data_in));
            check($sformatf("vec%0d rep_info", i), 64'(data_out[47:32]), 64'(vecs[i].rep));
            check($sformatf("vec%0d zero_info", i), 64'(data_out[51:48]), 64'(vecs[i].zero));
        end
        // DONE: no further accepts, pending output drains.
        data_in = grp(9, 9, 9, 9);
        cycle();
        check("done avail_out", 64'(obs_avail), 64'd0);
        check("done valid drop", 64'(valid_out), 64'd0);
        cycle();

        // Backpressure: output holds for 3 cycles, then next group goes in the release cycle.
        do_configure(1, 2);
        data_in = grp(4, 5, 4, 0); valid_in = 1'b1; avail_in = 1'b1;
        cycle();
        held = data_out;
        data_in = grp(6, 6, 1, 2); avail_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp avail_out", 64'(obs_avail), 64'd0);
            check("bp hold data", 64'(data_out), 64'(held));
            check("bp hold valid", 64'(valid_out), 64'd1);
        end
        avail_in = 1'b1;
        cycle();
        check("bp release accept", 64'(data_out[31:0]), 64'(grp(6, 6, 1, 2)));
        valid_in = 1'b0;
        cycle();

        // 2 x 3 bounds: exactly six accepts, twice.
        for (int r = 0; r < 2; r++) begin
            do_configure(2, 3);
            acc_cnt = 0;
            valid_in = 1'b1; avail_in = 1'b1;
            for (int i = 0; i < 9; i++) begin
                data_in = 32'($urandom);
                cycle();
                if (obs_avail) acc_cnt++;
            end
            check("2x3 accept count", 64'(acc_cnt), 64'd6);
        end

        // Zero bound goes straight to DONE.
        do_configure(0, 5);
        valid_in = 1'b1;
        cycle();

        // Randomized traffic with small value alphabet to hit repeats and zeros.
        for (int i = 0; i < 400; i++) begin
            configure          = ($urandom_range(0, 19) == 0);
            num_iters          = 16'($urandom_range(0, 3));
            num_reads_per_iter = 16'($urandom_range(0, 3));
            valid_in           = ($urandom_range(0, 9) < 7);
            avail_in           = ($urandom_range(0, 9) < 6);
            data_in = grp(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                          8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
            cycle();
        end
        configure = 1'b0;

        // Asynchronous reset while an output is pending.
        do_configure(1, 4);
        data_in = grp(1, 1, 0, 2); valid_in = 1'b1; avail_in = 1'b0;
        cycle();
        check("pre-rst valid_out", 64'(valid_out), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid_out", 64'(valid_out), 64'd0);
        check("async rst avail_out", 64'(avail_out), 64'd0);
        check("async rst data_out", 64'(data_out), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        avail_in = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
